cam_enroll_ctrl: RTL and testbench
==================================

# cam_enroll_ctrl

Enrollment controller sitting directly upstream of the `cam` block. Accepts key-enroll requests over a valid/ready handshake, checks for duplicates with a CAM lookup, allocates the lowest free CAM slot, issues the CAM write and honours `busy`, then returns a one-cycle status response. It owns the slot-occupancy bitmap, so stale CAM contents after reset are never reported as duplicates.

## Interface
- DATA_WIDTH, 4, key width; equals CAM `DATA_WIDTH`
- ADDR_WIDTH, 2, log2 of CAM depth; equals CAM `ADDR_WIDTH`
- LOOKUP_LAT, 1, cycles from driving `cam_din` to valid `cam_match`/`cam_match_addr` (≥1)
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_key  in  DATA_WIDTH  key to enroll
- resp_valid  out  1  one-cycle response strobe
- resp_status  out  2  00 OK, 01 DUPLICATE, 10 FULL, 11 NOT_FOUND (delete only)
- resp_addr  out  ADDR_WIDTH  slot written, matched or freed
- used_count  out  ADDR_WIDTH+1  number of occupied slots
- cam_din  out  DATA_WIDTH  CAM lookup key
- cam_cmp_din  out  DATA_WIDTH  CAM write data
- cam_write_addr  out  ADDR_WIDTH  CAM write address
- cam_write_enable  out  1  CAM write strobe
- cam_busy  in  1  CAM write in progress
- cam_match  in  1  CAM hit
- cam_match_addr  in  ADDR_WIDTH  CAM hit address

## Operation
- States: IDLE, LOOKUP, WRITE, WAIT, RESP.
- IDLE: `req_ready`=1; on `req_valid && req_ready`, capture key into `key_q`, clear lookup counter → LOOKUP.
- LOOKUP: drive `cam_din`=`key_q` for LOOKUP_LAT cycles; sample on the last cycle. Qualified hit = `cam_match && valid[cam_match_addr]`.
  - Hit → RESP, status DUPLICATE, `resp_addr`=`cam_match_addr`.
  - No hit, all valid bits set → RESP, status FULL, `resp_addr`=0.
  - Otherwise latch the lowest free index → WRITE.
- DUPLICATE takes precedence over FULL.
- WRITE: hold while `cam_busy`=1. When `cam_busy`=0, assert `cam_write_enable` for exactly one cycle with `cam_write_addr`=slot and `cam_cmp_din`=`cam_din`=`key_q` → WAIT.
- WAIT: minimum one cycle; leave when `cam_busy`=0. Set `valid[slot]`, increment `used_count` → RESP, status OK.
- RESP: `resp_valid`=1 for one cycle → IDLE.
- `req_ready`=0 in every state except IDLE. Requests are never dropped: a held `req_valid` is accepted on return to IDLE.

## Timing
- Reset (`rst`=0 at an edge), including mid-operation: state→IDLE, bitmap cleared, `used_count`=0. `req_ready`, `resp_valid`, `resp_status`, `resp_addr`, `cam_write_enable`, `cam_write_addr`, `cam_din`, `cam_cmp_din` are all 0. A pending write is aborted with no strobe. `req_ready` rises the first cycle after release.
- All outputs are registered.
- Latency, with handshake at edge T, LOOKUP_LAT=1 and `cam_busy` held low:
  - OK: `resp_valid` at T+4.
  - DUPLICATE or FULL: `resp_valid` at T+2.
- Each cycle of `cam_busy`=1 in WRITE or WAIT adds one cycle.
- `used_count` saturates at 2^ADDR_WIDTH. It only changes on OK, or on a delete hit when the delete feature is compiled in.

## Configuration
- `CAM_ENROLL_DELETE_EN`:
  - Defined: adds input `req_op` (1 bit; 0 enroll, 1 delete), captured at handshake.
  - Delete path: LOOKUP, then RESP. Qualified hit clears `valid[addr]`, decrements `used_count`, status OK, `resp_addr`=hit address. Miss gives NOT_FOUND. No CAM write is issued.
  - Undefined: no `req_op` port, and status 11 is never produced.

## Structure
- Package `cam_enroll_pkg`: status encodings (OK, DUPLICATE, FULL, NOT_FOUND) and the state enum.
- Sub-module `free_slot_finder`: parameterised priority encoder over the valid bitmap. Outputs `any_free` and the lowest free index.

## Test plan
All scenarios use DATA_WIDTH=4, ADDR_WIDTH=2, LOOKUP_LAT=1, with a CAM model.
- Enroll keys 0011, 0101, 1011, 1111 → OK at addresses 0,1,2,3; `used_count` 1→4; each `resp_valid` 4 cycles after handshake.
- Enroll 0101 again → DUPLICATE, `resp_addr`=1, `resp_valid` 2 cycles after handshake, no `cam_write_enable`.
- Enroll 0000 when full → FULL, no write, `used_count` stays 4.
- After reset, CAM still holds 0011 at address 0. Enroll 0011 → OK at address 0, since the stale hit is ignored.
- Hold `cam_busy`=1 for 3 cycles on entry to WRITE → write strobe is delayed 3 cycles; response at T+7; strobe is exactly one cycle wide.
- Assert reset while in WAIT → next cycle: outputs zero, `used_count`=0. With `CAM_ENROLL_DELETE_EN`, delete 0101 → OK at address 1; repeating it → NOT_FOUND.

Source files
------------

// File: rtl/cam_enroll_pkg.sv
// Shared encodings for the CAM enrollment controller: response status codes and FSM states.
package cam_enroll_pkg;

  typedef enum logic [1:0] {
    STATUS_OK        = 2'b00,
    STATUS_DUPLICATE = 2'b01,
    STATUS_FULL      = 2'b10,
    STATUS_NOT_FOUND = 2'b11
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_WRITE  = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_e;

endpackage

// File: rtl/cam_enroll_ctrl_if.sv
// Request/response bus of the enrollment controller. req_op exists only when CAM_ENROLL_DELETE_EN is defined.
interface cam_enroll_ctrl_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 2
);
  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // the requester holds req_valid/req_key (and req_op) stable until then.
  // resp_valid is a single-cycle strobe with resp_status/resp_addr valid alongside it.
  logic                  req_valid;
  logic                  req_ready;
  logic [DATA_WIDTH-1:0] req_key;
`ifdef CAM_ENROLL_DELETE_EN
  logic                  req_op;
`endif
  logic                  resp_valid;
  logic [1:0]            resp_status;
  logic [ADDR_WIDTH-1:0] resp_addr;

  modport master (
`ifdef CAM_ENROLL_DELETE_EN
    output req_op,
`endif
    output req_valid, req_key,
    input  req_ready, resp_valid, resp_status, resp_addr
  );

  modport slave (
`ifdef CAM_ENROLL_DELETE_EN
    input  req_op,
`endif
    input  req_valid, req_key,
    output req_ready, resp_valid, resp_status, resp_addr
  );
endinterface

// File: rtl/cam_enroll_ctrl_free_slot_finder.sv
// Priority encoder returning the lowest clear bit of the slot-occupancy bitmap.
module free_slot_finder #(
  parameter int ADDR_WIDTH = 2
) (
  input  logic [(1<<ADDR_WIDTH)-1:0] valid_bits,
  output logic                       any_free,
  output logic [ADDR_WIDTH-1:0]      free_idx
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Scan high to low so the lowest free index is the last one written.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_bits[i]) begin
        any_free = 1'b1;
        free_idx = ADDR_WIDTH'(i);
      end
    end
  end
endmodule

// File: rtl/cam_enroll_ctrl.sv
// Enrollment controller upstream of a CAM: duplicate check, lowest-free-slot allocation, CAM write.
// Optional delete operation is compiled in with CAM_ENROLL_DELETE_EN.
module cam_enroll_ctrl
  import cam_enroll_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int LOOKUP_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  cam_enroll_ctrl_if.slave      req_if,
  output logic [ADDR_WIDTH:0]   used_count,
  output logic [DATA_WIDTH-1:0] cam_din,
  output logic [DATA_WIDTH-1:0] cam_cmp_din,
  output logic [ADDR_WIDTH-1:0] cam_write_addr,
  output logic                  cam_write_enable,
  input  logic                  cam_busy,
  input  logic                  cam_match,
  input  logic [ADDR_WIDTH-1:0] cam_match_addr,
  output state_e                dbg_state
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = (LOOKUP_LAT > 1) ? $clog2(LOOKUP_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOOKUP_LAT - 1);
  localparam logic [ADDR_WIDTH:0] USED_MAX = (ADDR_WIDTH+1)'(DEPTH);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] key_q, key_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] slot_q, slot_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [ADDR_WIDTH:0]   used_q, used_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  status_e               resp_status_q, resp_status_d;
  logic [ADDR_WIDTH-1:0] resp_addr_q, resp_addr_d;
  logic [DATA_WIDTH-1:0] cam_din_q, cam_din_d;
  logic [DATA_WIDTH-1:0] cmp_q, cmp_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                  we_q, we_d;
`ifdef CAM_ENROLL_DELETE_EN
  logic                  op_q, op_d;
`endif

  logic                  any_free;
  logic [ADDR_WIDTH-1:0] free_idx;
  logic                  hit;

  free_slot_finder #(.ADDR_WIDTH(ADDR_WIDTH)) u_free_slot_finder (
    .valid_bits (valid_q),
    .any_free   (any_free),
    .free_idx   (free_idx)
  );

  // CAM contents survive a controller reset, so a hit only counts on an occupied slot.
  assign hit = cam_match && valid_q[cam_match_addr];

  always_comb begin
    state_d       = state_q;
    key_d         = key_q;
    cnt_d         = cnt_q;
    slot_d        = slot_q;
    valid_d       = valid_q;
    used_d        = used_q;
    resp_status_d = resp_status_q;
    resp_addr_d   = resp_addr_q;
    cam_din_d     = cam_din_q;
    cmp_d         = cmp_q;
    waddr_d       = waddr_q;
    we_d          = 1'b0;
`ifdef CAM_ENROLL_DELETE_EN
    op_d          = op_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_if.req_valid && req_ready_q) begin
          key_d     = req_if.req_key;
          cam_din_d = req_if.req_key;
          cnt_d     = '0;
`ifdef CAM_ENROLL_DELETE_EN
          op_d      = req_if.req_op;
`endif
          state_d   = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (cnt_q == CNT_LAST) begin
`ifdef CAM_ENROLL_DELETE_EN
          if (op_q) begin
            if (hit) begin
              valid_d[cam_match_addr] = 1'b0;
              if (used_q != '0) used_d = used_q - 1'b1;
              resp_status_d = STATUS_OK;
              resp_addr_d   = cam_match_addr;
            end else begin
              resp_status_d = STATUS_NOT_FOUND;
              resp_addr_d   = '0;
            end
            state_d = S_RESP;
          end else
`endif
          if (hit) begin
            resp_status_d = STATUS_DUPLICATE;
            resp_addr_d   = cam_match_addr;
            state_d       = S_RESP;
          end else if (!any_free) begin
            resp_status_d = STATUS_FULL;
            resp_addr_d   = '0;
            state_d       = S_RESP;
          end else begin
            slot_d  = free_idx;
            state_d = S_WRITE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (!cam_busy) begin
          we_d      = 1'b1;
          waddr_d   = slot_q;
          cmp_d     = key_q;
          cam_din_d = key_q;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!cam_busy) begin
          valid_d[slot_q] = 1'b1;
          if (used_q < USED_MAX) used_d = used_q + 1'b1;
          resp_status_d = STATUS_OK;
          resp_addr_d   = slot_q;
          state_d       = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      key_q         <= '0;
      cnt_q         <= '0;
      slot_q        <= '0;
      valid_q       <= '0;
      used_q        <= '0;
      req_ready_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_status_q <= STATUS_OK;
      resp_addr_q   <= '0;
      cam_din_q     <= '0;
      cmp_q         <= '0;
      waddr_q       <= '0;
      we_q          <= 1'b0;
`ifdef CAM_ENROLL_DELETE_EN
      op_q          <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      key_q         <= key_d;
      cnt_q         <= cnt_d;
      slot_q        <= slot_d;
      valid_q       <= valid_d;
      used_q        <= used_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_status_q <= resp_status_d;
      resp_addr_q   <= resp_addr_d;
      cam_din_q     <= cam_din_d;
      cmp_q         <= cmp_d;
      waddr_q       <= waddr_d;
      we_q          <= we_d;
`ifdef CAM_ENROLL_DELETE_EN
      op_q          <= op_d;
`endif
    end
  end

  assign req_if.req_ready   = req_ready_q;
  assign req_if.resp_valid  = resp_valid_q;
  assign req_if.resp_status = resp_status_q;
  assign req_if.resp_addr   = resp_addr_q;
  assign used_count         = used_q;
  assign cam_din            = cam_din_q;
  assign cam_cmp_din        = cmp_q;
  assign cam_write_addr     = waddr_q;
  assign cam_write_enable   = we_q;
  assign dbg_state          = state_q;
endmodule

// File: tb/tb_cam_enroll_ctrl.sv
// Directed bench for cam_enroll_ctrl with a behavioural 4-entry CAM; delete checks need CAM_ENROLL_DELETE_EN.
module tb_cam_enroll_ctrl;
  import cam_enroll_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] used_count;
  logic [3:0] cam_din, cam_cmp_din;
  logic [1:0] cam_write_addr, cam_match_addr;
  logic       cam_write_enable, cam_busy, cam_match;
  state_e     dbg_state;

  int total = 0;
  int bad   = 0;

  logic [5:0] exp_q[$];
  logic [5:0] wr_q[$];

  always #5 clk = ~clk;

  cam_enroll_ctrl_if #(.DATA_WIDTH(4), .ADDR_WIDTH(2)) bus ();

  cam_enroll_ctrl #(.DATA_WIDTH(4), .ADDR_WIDTH(2), .LOOKUP_LAT(1)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_if           (bus),
    .used_count       (used_count),
    .cam_din          (cam_din),
    .cam_cmp_din      (cam_cmp_din),
    .cam_write_addr   (cam_write_addr),
    .cam_write_enable (cam_write_enable),
    .cam_busy         (cam_busy),
    .cam_match        (cam_match),
    .cam_match_addr   (cam_match_addr),
    .dbg_state        (dbg_state)
  );

  // Behavioural CAM: contents are never cleared by the controller reset.
  logic [3:0] cam_mem [4];
  logic [3:0] cam_vld = 4'b0000;

  always @(posedge clk) begin
    if (cam_write_enable) begin
      cam_mem[cam_write_addr] <= cam_cmp_din;
      cam_vld[cam_write_addr] <= 1'b1;
      wr_q.push_back({cam_write_addr, cam_cmp_din});
    end
  end

  always_comb begin
    cam_match      = 1'b0;
    cam_match_addr = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (cam_vld[i] && cam_mem[i] == cam_din) begin
        cam_match      = 1'b1;
        cam_match_addr = 2'(i);
      end
    end
  end

  // One transaction; lat counts negedges after the handshake edge until resp_valid is seen.
  task automatic send(input logic [3:0] key, input logic op, input int busy_cycles,
                      output int lat, output logic [1:0] st, output logic [1:0] addr,
                      output int n_we, output logic [3:0] we_key, output logic [3:0] we_din,
                      output logic [1:0] we_addr);
    int guard;
    lat = 0; n_we = 0; st = 2'b00; addr = 2'b00;
    we_key = 4'h0; we_din = 4'h0; we_addr = 2'b00;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_key   = key;
`ifdef CAM_ENROLL_DELETE_EN
    bus.req_op    = op;
`else
    if (op) $display("note: delete op ignored in this build");
`endif
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (!bus.req_ready) begin
      bad++;
      $display("FAIL handshake_timeout key=%b req_ready=%b required=1", key, bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_valid = 1'b0;
      cam_busy = (k >= 2 && k <= 1 + busy_cycles);
      if (cam_write_enable) begin
        n_we++;
        we_key  = cam_cmp_din;
        we_din  = cam_din;
        we_addr = cam_write_addr;
      end
      if (bus.resp_valid) begin
        lat  = k;
        st   = bus.resp_status;
        addr = bus.resp_addr;
      end
    end
    cam_busy = 1'b0;
    total++;
    if (lat == 0) begin
      bad++;
      $display("FAIL resp_timeout key=%b no resp_valid within 20 cycles", key);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%b exp=0", bus.req_ready); end
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b exp=0", bus.resp_valid); end
    total++; if ({bus.resp_status, bus.resp_addr} !== 4'b0000) begin bad++; $display("FAIL rst_resp_fields got=%b exp=0000", {bus.resp_status, bus.resp_addr}); end
    total++; if ({cam_write_enable, cam_write_addr} !== 3'b000) begin bad++; $display("FAIL rst_cam_write got=%b exp=000", {cam_write_enable, cam_write_addr}); end
    total++; if ({cam_din, cam_cmp_din} !== 8'h00) begin bad++; $display("FAIL rst_cam_data got=%h exp=00", {cam_din, cam_cmp_din}); end
    total++; if (used_count !== 3'd0) begin bad++; $display("FAIL rst_used_count got=%0d exp=0", used_count); end
    total++; if (dbg_state !== S_IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, S_IDLE); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", bus.req_ready); end
  endtask

  task automatic test_enroll_fill();
    logic [3:0] keys [4];
    int lat, n_we; logic [1:0] st, addr, wa; logic [3:0] wk, wd;
    keys[0] = 4'b0011; keys[1] = 4'b0101; keys[2] = 4'b1011; keys[3] = 4'b1111;
    wr_q.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({2'(i), keys[i]});
      send(keys[i], 1'b0, 0, lat, st, addr, n_we, wk, wd, wa);
      total++; if (st !== 2'b00 || addr !== 2'(i)) begin bad++; $display("FAIL fill_resp[%0d] got st=%b addr=%0d exp st=00 addr=%0d", i, st, addr, i); end
      total++; if (lat != 4) begin bad++; $display("FAIL fill_latency[%0d] got=%0d exp=4", i, lat); end
      total++; if (n_we != 1 || wk !== keys[i] || wd !== keys[i] || wa !== 2'(i)) begin bad++; $display("FAIL fill_write[%0d] got n=%0d cmp=%b din=%b addr=%0d exp n=1 key=%b addr=%0d", i, n_we, wk, wd, wa, keys[i], i); end
      total++; if (used_count !== 3'(i + 1)) begin bad++; $display("FAIL fill_used[%0d] got=%0d exp=%0d", i, used_count, i + 1); end
    end
    total++;
    if (wr_q.size() != exp_q.size()) begin bad++; $display("FAIL fill_write_count got=%0d exp=%0d", wr_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && wr_q.size() > 0) begin
      logic [5:0] e, a;
      e = exp_q.pop_front(); a = wr_q.pop_front();
      total++; if (a !== e) begin bad++; $display("FAIL fill_scoreboard got=%h exp=%h", a, e); end
    end
  endtask

  task automatic test_duplicate();
    int lat, n_we; logic [1:0] st, addr, wa; logic [3:0] wk, wd;
    send(4'b0101, 1'b0, 0, lat, st, addr, n_we, wk, wd, wa);
    total++; if (st !== 2'b01 || addr !== 2'd1) begin bad++; $display("FAIL dup_resp got st=%b addr=%0d exp st=01 addr=1", st, addr); end
    total++; if (lat != 2) begin bad++; $display("FAIL dup_latency got=%0d exp=2", lat); end
    total++; if (n_we != 0) begin bad++; $display("FAIL dup_no_write got=%0d exp=0", n_we); end
    total++; if (used_count !== 3'd4) begin bad++; $display("FAIL dup_used got=%0d exp=4", used_count); end
  endtask

  task automatic test_full();
    int lat, n_we; logic [1:0] st, addr, wa; logic [3:0] wk, wd;
    send(4'b0000, 1'b0, 0, lat, st, addr, n_we, wk, wd, wa);
    total++; if (st !== 2'b10 || addr !== 2'd0) begin bad++; $display("FAIL full_resp got st=%b addr=%0d exp st=10 addr=0", st, addr); end
    total++; if (lat != 2) begin bad++; $display("FAIL full_latency got=%0d exp=2", lat); end
    total++; if (n_we != 0) begin bad++; $display("FAIL full_no_write got=%0d exp=0", n_we); end
    total++; if (used_count !== 3'd4) begin bad++; $display("FAIL full_used got=%0d exp=4", used_count); end
  endtask

  task automatic test_stale_after_reset();
    int lat, n_we; logic [1:0] st, addr, wa; logic [3:0] wk, wd;
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    total++; if (used_count !== 3'd0) begin bad++; $display("FAIL stale_used_after_rst got=%0d exp=0", used_count); end
    send(4'b0011, 1'b0, 0, lat, st, addr, n_we, wk, wd, wa);
    total++; if (st !== 2'b00 || addr !== 2'd0) begin bad++; $display("FAIL stale_resp got st=%b addr=%0d exp st=00 addr=0", st, addr); end
    total++; if (lat != 4 || n_we != 1) begin bad++; $display("FAIL stale_timing got lat=%0d n_we=%0d exp lat=4 n_we=1", lat, n_we); end
    total++; if (used_count !== 3'd1) begin bad++; $display("FAIL stale_used got=%0d exp=1", used_count); end
  endtask

  task automatic test_busy();
    int lat, n_we; logic [1:0] st, addr, wa; logic [3:0] wk, wd;
    send(4'b1000, 1'b0, 3, lat, st, addr, n_we, wk, wd, wa);
    total++; if (st !== 2'b00 || addr !== 2'd1) begin bad++; $display("FAIL busy_resp got st=%b addr=%0d exp st=00 addr=1", st, addr); end
    total++; if (lat != 7) begin bad++; $display("FAIL busy_latency got=%0d exp=7", lat); end
    total++; if (n_we != 1 || wa !== 2'd1 || wk !== 4'b1000) begin bad++; $display("FAIL busy_strobe got n=%0d addr=%0d key=%b exp n=1 addr=1 key=1000", n_we, wa, wk); end
    total++; if (used_count !== 3'd2) begin bad++; $display("FAIL busy_used got=%0d exp=2", used_count); end
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_key   = 4'b1110;
`ifdef CAM_ENROLL_DELETE_EN
    bus.req_op    = 1'b0;
`endif
    total++;
    if (!bus.req_ready) begin bad++; $display("FAIL rwait_not_ready got=%b exp=1", bus.req_ready); end
    @(negedge clk); bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (dbg_state !== S_WAIT) begin bad++; $display("FAIL rwait_in_wait got=%0d exp=%0d", dbg_state, S_WAIT); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (dbg_state !== S_IDLE || used_count !== 3'd0) begin bad++; $display("FAIL rwait_state got st=%0d used=%0d exp st=0 used=0", dbg_state, used_count); end
    total++; if ({bus.req_ready, bus.resp_valid, bus.resp_status, bus.resp_addr} !== 6'b0) begin bad++; $display("FAIL rwait_resp_outputs got=%b exp=000000", {bus.req_ready, bus.resp_valid, bus.resp_status, bus.resp_addr}); end
    total++; if ({cam_write_enable, cam_write_addr, cam_din, cam_cmp_din} !== 11'b0) begin bad++; $display("FAIL rwait_cam_outputs got=%b exp=0", {cam_write_enable, cam_write_addr, cam_din, cam_cmp_din}); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rwait_release_ready got=%b exp=1", bus.req_ready); end
  endtask

`ifdef CAM_ENROLL_DELETE_EN
  task automatic test_delete();
    int lat, n_we; logic [1:0] st, addr, wa; logic [3:0] wk, wd;
    send(4'b0011, 1'b0, 0, lat, st, addr, n_we, wk, wd, wa);
    send(4'b0101, 1'b0, 0, lat, st, addr, n_we, wk, wd, wa);
    total++; if (st !== 2'b00 || addr !== 2'd1) begin bad++; $display("FAIL del_setup got st=%b addr=%0d exp st=00 addr=1", st, addr); end
    send(4'b0101, 1'b1, 0, lat, st, addr, n_we, wk, wd, wa);
    total++; if (st !== 2'b00 || addr !== 2'd1) begin bad++; $display("FAIL del_hit got st=%b addr=%0d exp st=00 addr=1", st, addr); end
    total++; if (lat != 2 || n_we != 0) begin bad++; $display("FAIL del_timing got lat=%0d n_we=%0d exp lat=2 n_we=0", lat, n_we); end
    total++; if (used_count !== 3'd1) begin bad++; $display("FAIL del_used got=%0d exp=1", used_count); end
    send(4'b0101, 1'b1, 0, lat, st, addr, n_we, wk, wd, wa);
    total++; if (st !== 2'b11 || addr !== 2'd0) begin bad++; $display("FAIL del_miss got st=%b addr=%0d exp st=11 addr=0", st, addr); end
    total++; if (used_count !== 3'd1) begin bad++; $display("FAIL del_miss_used got=%0d exp=1", used_count); end
  endtask
`endif

  initial begin
    bus.req_valid = 1'b0;
    bus.req_key   = 4'h0;
`ifdef CAM_ENROLL_DELETE_EN
    bus.req_op    = 1'b0;
`endif
    cam_busy = 1'b0;
    test_reset();
    test_enroll_fill();
    test_duplicate();
    test_full();
    test_stale_after_reset();
    test_busy();
    test_reset_in_wait();
`ifdef CAM_ENROLL_DELETE_EN
    test_delete();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
